// File: rtl/trace_pkg.sv
// Shared types and constants for the trace RAM.
// Used by both the capture unit and the dump reader.
package trace_pkg;
   localparam int DEPTH = 384;
   localparam int AW    = 9;
   localparam int DW    = 8;

   typedef logic [AW-1:0] addr_t;
   typedef logic [DW-1:0] data_t;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_TX, DONE} dump_state_t;

   localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

   // A capture pointer outside the buffer means "start at the beginning".
   function automatic addr_t clamp_addr(input addr_t a);
      return (a > LAST_ADDR) ? '0 : a;
   endfunction
endpackage

// File: rtl/trace_addr_ctr.sv
// Address register for the trace RAM.
// It wraps modulo DEPTH, and the capture write pointer reuses it.
module trace_addr_ctr
   import trace_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  addr_t load_addr,
   input  logic  inc,
   output addr_t addr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         addr <= '0;
      else if (load)
         addr <= load_addr;
      else if (inc)
         addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
   end

endmodule

// File: rtl/trace_dump.sv
// Streams the circular trace buffer, oldest sample first, to the UART one byte per handshake.
//  state   | meaning
//  IDLE    | waiting for dump_start with capture_done
//  FETCH   | first RAM read in flight, hold register filled on exit
//  LOAD    | waiting for tx_rdy, then strobe trmt and prefetch next sample
//  WAIT_TX | skip the trmt cycle, then wait for tx_rdy
//  DONE    | pulse dump_done / clr_cap_done, back to IDLE
module trace_dump
   import trace_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  dump_start,
   input  logic  dump_abort,
   input  logic  capture_done,
   input  addr_t trace_end,
   input  data_t ram_rdata,
   input  logic  tx_rdy,
   output logic  ram_en,
   output addr_t ram_addr,
   output data_t tx_data,
   output logic  trmt,
   output logic  dump_busy,
   output logic  dump_done,
   output logic  clr_cap_done
);

   dump_state_t state, state_nxt;
   addr_t       sent, sent_nxt;
   data_t       hold;
   logic        rd_pend;
   logic        ctr_load, ctr_inc, tx_load;
   logic        ram_en_nxt, trmt_nxt, busy_nxt, done_nxt;

   trace_addr_ctr u_addr (
      .clk       (clk),
      .rst       (rst),
      .load      (ctr_load),
      .load_addr (clamp_addr(trace_end)),
      .inc       (ctr_inc),
      .addr      (ram_addr)
   );

   always_comb begin
      state_nxt  = state;
      sent_nxt   = sent;
      ctr_load   = 1'b0;
      ctr_inc    = 1'b0;
      tx_load    = 1'b0;
      ram_en_nxt = 1'b0;
      trmt_nxt   = 1'b0;
      busy_nxt   = dump_busy;
      done_nxt   = 1'b0;
      if (state != IDLE && dump_abort) begin
         state_nxt = IDLE;
         busy_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dump_start && capture_done && !dump_abort) begin
                  ctr_load   = 1'b1;
                  ram_en_nxt = 1'b1;
                  sent_nxt   = '0;
                  busy_nxt   = 1'b1;
                  state_nxt  = FETCH;
               end
            end
            FETCH: begin
               if (rd_pend)
                  state_nxt = LOAD;
            end
            LOAD: begin
               if (tx_rdy) begin
                  trmt_nxt = 1'b1;
                  tx_load  = 1'b1;
                  if (sent == LAST_ADDR) begin
                     state_nxt = DONE;
                  end else begin
                     sent_nxt   = sent + 1'b1;
                     ctr_inc    = 1'b1;
                     ram_en_nxt = 1'b1;
                     state_nxt  = WAIT_TX;
                  end
               end
            end
            WAIT_TX: begin
               // trmt is still high in the first cycle; tx_rdy has not dropped yet
               if (!trmt && tx_rdy)
                  state_nxt = LOAD;
            end
            DONE: begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sent         <= '0;
         hold         <= '0;
         rd_pend      <= 1'b0;
         ram_en       <= 1'b0;
         trmt         <= 1'b0;
         tx_data      <= '0;
         dump_busy    <= 1'b0;
         dump_done    <= 1'b0;
         clr_cap_done <= 1'b0;
      end else begin
         state        <= state_nxt;
         sent         <= sent_nxt;
         rd_pend      <= ram_en;
         ram_en       <= ram_en_nxt;
         trmt         <= trmt_nxt;
         dump_busy    <= busy_nxt;
         dump_done    <= done_nxt;
         clr_cap_done <= done_nxt;
         if (rd_pend)
            hold <= ram_rdata;
         if (tx_load)
            tx_data <= hold;
      end
   end

endmodule

// File: tb/tb_trace_dump.sv
// Scoreboard bench for trace_dump: expected reads/bytes queued at dump start, checked by a monitor.
module tb_trace_dump;
   localparam int N = 384;

   logic       clk = 1'b0;
   logic       rst;
   logic       dump_start, dump_abort, capture_done;
   logic [8:0] trace_end;
   logic [7:0] ram_rdata;
   logic       tx_rdy;
   logic       ram_en, trmt, dump_busy, dump_done, clr_cap_done;
   logic [8:0] ram_addr;
   logic [7:0] tx_data;

   trace_dump dut (
      .clk          (clk),
      .rst          (rst),
      .dump_start   (dump_start),
      .dump_abort   (dump_abort),
      .capture_done (capture_done),
      .trace_end    (trace_end),
      .ram_rdata    (ram_rdata),
      .tx_rdy       (tx_rdy),
      .ram_en       (ram_en),
      .ram_addr     (ram_addr),
      .tx_data      (tx_data),
      .trmt         (trmt),
      .dump_busy    (dump_busy),
      .dump_done    (dump_done),
      .clr_cap_done (clr_cap_done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:N-1];
   always @(posedge clk)
      if (ram_en)
         ram_rdata <= (ram_addr < 9'(N)) ? mem[ram_addr] : 8'h00;

   int tx_busy = 10;
   int tx_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_rdy <= 1'b1;
         tx_cnt <= 0;
      end else if (trmt) begin
         tx_rdy <= 1'b0;
         tx_cnt <= tx_busy;
      end else if (!tx_rdy) begin
         if (tx_cnt <= 1) tx_rdy <= 1'b1;
         else tx_cnt <= tx_cnt - 1;
      end
   end

   logic [7:0] exp_data_q[$];
   logic [8:0] exp_addr_q[$];
   int checks = 0, errors = 0;
   int done_allow = 0, done_cnt = 0, trmt_cnt = 0;
   logic [7:0] last_tx = 8'h00;
   logic [8:0] exp_a;
   logic [7:0] exp_d;

   always @(negedge clk) begin
      if (rst) begin
         last_tx = 8'h00;
      end else begin
         if (ram_en) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
               errors++;
               $display("FAIL ram_en_spurious: read at addr %0d, no read expected", ram_addr);
            end else begin
               exp_a = exp_addr_q.pop_front();
               if (ram_addr !== exp_a) begin
                  errors++;
                  $display("FAIL ram_addr: got %0d expected %0d", ram_addr, exp_a);
               end
            end
         end
         checks++;
         if (trmt) begin
            trmt_cnt++;
            if (tx_rdy !== 1'b1) begin
               errors++;
               $display("FAIL trmt_rdy: trmt with tx_rdy=%b, required 1", tx_rdy);
            end
            checks++;
            if (exp_data_q.size() == 0) begin
               errors++;
               $display("FAIL trmt_spurious: byte %0h sent, none expected", tx_data);
            end else begin
               exp_d = exp_data_q.pop_front();
               if (tx_data !== exp_d) begin
                  errors++;
                  $display("FAIL tx_data: got %0h expected %0h", tx_data, exp_d);
               end
            end
            last_tx = tx_data;
         end else if (tx_data !== last_tx) begin
            errors++;
            $display("FAIL tx_hold: tx_data %0h changed without trmt, held %0h", tx_data, last_tx);
         end
         if (dump_done || clr_cap_done) begin
            done_cnt++;
            checks++;
            if (done_allow == 0) begin
               errors++;
               $display("FAIL done_spurious: dump_done=%b clr=%b, none expected", dump_done, clr_cap_done);
            end else begin
               done_allow--;
            end
            checks++;
            if (clr_cap_done !== dump_done || dump_busy !== 1'b0) begin
               errors++;
               $display("FAIL done_pulse: done=%b clr=%b busy=%b, required 1 1 0", dump_done, clr_cap_done, dump_busy);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < N; i++)
         mem[i] = (mode == 0) ? 8'(i) : 8'(i * 7 + 3);
   endtask

   task automatic flush();
      exp_data_q.delete();
      exp_addr_q.delete();
      done_allow = 0;
   endtask

   task automatic start_dump(input logic [8:0] te, input logic [8:0] te_after);
      int s;
      s = (int'(te) >= N) ? 0 : int'(te);
      for (int i = 0; i < N; i++) begin
         exp_addr_q.push_back(9'((s + i) % N));
         exp_data_q.push_back(mem[(s + i) % N]);
      end
      done_allow++;
      @(negedge clk);
      trace_end  = te;
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      trace_end  = te_after;
   endtask

   task automatic wait_done(input int budget, input string nm);
      int d0, n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL %s_timeout: no dump_done within %0d cycles", nm, budget);
      end
      chk({nm, "_left_bytes"}, exp_data_q.size(), 0);
      chk({nm, "_left_reads"}, exp_addr_q.size(), 0);
   endtask

   task automatic abort_after(input int base, input int n, input string nm);
      int k;
      k = 0;
      while (trmt_cnt - base < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_reached"}, trmt_cnt - base, n);
      dump_abort = 1'b1;
      @(negedge clk);
      dump_abort = 1'b0;
      chk({nm, "_busy"}, dump_busy, 0);
      chk({nm, "_ram_en"}, ram_en, 0);
      flush();
      repeat (60) @(negedge clk);
      chk({nm, "_no_more_trmt"}, trmt_cnt - base, n);
      chk({nm, "_idle_busy"}, dump_busy, 0);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_ram_en"}, ram_en, 0);
      chk({nm, "_ram_addr"}, ram_addr, 0);
      chk({nm, "_tx_data"}, tx_data, 0);
      chk({nm, "_trmt"}, trmt, 0);
      chk({nm, "_busy"}, dump_busy, 0);
      chk({nm, "_done"}, dump_done, 0);
      chk({nm, "_clr"}, clr_cap_done, 0);
   endtask

   int base;

   initial begin
      rst = 1'b1;
      dump_start = 1'b0;
      dump_abort = 1'b0;
      capture_done = 1'b0;
      trace_end = 9'd0;
      fill(0);
      #12;
      chk_reset_outs("reset");
      @(negedge clk);
      rst = 1'b0;
      capture_done = 1'b1;

      // T1: full dump from 0
      base = trmt_cnt;
      start_dump(9'd0, 9'd200);
      wait_done(8000, "t1");
      chk("t1_count", trmt_cnt - base, N);

      // T2: wrap across DEPTH-1, trace_end changed mid-dump
      fill(1);
      base = trmt_cnt;
      start_dump(9'd380, 9'd5);
      wait_done(8000, "t2");
      chk("t2_count", trmt_cnt - base, N);

      // T3: abort after 5 bytes, then restart at same address
      fill(0);
      base = trmt_cnt;
      start_dump(9'd100, 9'd100);
      abort_after(base, 5, "t3");
      base = trmt_cnt;
      start_dump(9'd100, 9'd300);
      wait_done(8000, "t3b");
      chk("t3b_count", trmt_cnt - base, N);

      // T4: ignored starts
      capture_done = 1'b0;
      @(negedge clk);
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      repeat (20) @(negedge clk);
      chk("t4_nocap_busy", dump_busy, 0);
      capture_done = 1'b1;
      dump_start = 1'b1;
      dump_abort = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      dump_abort = 1'b0;
      repeat (20) @(negedge clk);
      chk("t4_abort_wins_busy", dump_busy, 0);

      // out-of-range trace_end starts at 0
      fill(1);
      base = trmt_cnt;
      start_dump(9'd450, 9'd450);
      abort_after(base, 3, "clamp");

      // T5: slow transmitter
      tx_busy = 50;
      base = trmt_cnt;
      start_dump(9'd7, 9'd7);
      wait_done(26000, "t5");
      chk("t5_count", trmt_cnt - base, N);

      // T6: async reset during byte 20, then fresh dump
      tx_busy = 10;
      fill(0);
      base = trmt_cnt;
      start_dump(9'd200, 9'd200);
      begin
         int k;
         k = 0;
         while (trmt_cnt - base < 20 && k < 3000) begin
            @(negedge clk);
            k++;
         end
      end
      chk("t6_reached", trmt_cnt - base, 20);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs("t6_async");
      flush();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      base = trmt_cnt;
      start_dump(9'd200, 9'd13);
      wait_done(8000, "t6");
      chk("t6_count", trmt_cnt - base, N);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
